uart_cmd_rx: RTL and testbench

Robot-side receiver for the 9600-baud 8N1 command link driven by the handset's UART transmitter.
- Deserialises bytes on `rx` and presents them on a valid/ready handshake.
- Decodes the command byte {mode[1:0], dir[2:0], 3'b000} into held motor-command outputs.
- A watchdog forces a stop command when the link goes quiet.
- Sits between the GPIO serial pin and the robot motion controller.

---
 rtl/robot_cmd_pkg.sv | 30 +++
 rtl/uart_rx_frame.sv | 122 ++++++++++++
 rtl/uart_cmd_rx.sv | 101 ++++++++++
 tb/tb_uart_cmd_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_cmd_pkg.sv
// Shared types for the handset-to-robot command link: motion encodings,
// receiver FSM states and the nominal baud divider.
package robot_cmd_pkg;

    typedef enum logic [2:0] {
        DIR_STOP  = 3'd0,
        DIR_FWD   = 3'd1,
        DIR_LEFT  = 3'd3,
        DIR_HALT  = 3'd4,
        DIR_RIGHT = 3'd5,
        DIR_BACK  = 3'd7
    } dir_t;

    typedef logic [1:0] mode_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    localparam int BAUD_DIV_50M_9600 = 5208;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// 8N1 frame receiver: 2-FF synchroniser, start/data/stop sampling FSM.
// UART_MAJORITY_SAMPLE_EN selects a 2-of-3 vote around every sample point.
module uart_rx_frame
    import robot_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = BAUD_DIV_50M_9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       good,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
`ifdef UART_MAJORITY_SAMPLE_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif
    // With voting the decision lands one cycle after the nominal point, so the
    // counter restarts at OFS to keep the bit period at exactly CLKS_PER_BIT.
    localparam logic [CW-1:0] START_PT = CW'(CLKS_PER_BIT / 2 + OFS);
    localparam logic [CW-1:0] BIT_PT   = CW'(CLKS_PER_BIT - 1 + OFS);
    localparam logic [CW-1:0] RELOAD   = CW'(OFS);

    logic [1:0]    sync_q;
    logic          rx_s;
    logic          bit_val;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx};
    end

`ifdef UART_MAJORITY_SAMPLE_EN
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= 2'b11;
        else        hist <= {hist[0], rx_s};
    end

    assign bit_val = maj3(hist[1], hist[0], rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            good      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            good      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    // The detection cycle itself is count 0.
                    if (!rx_s) begin
                        state <= RX_START;
                        cnt   <= CW'(1);
                    end
                end
                RX_START: begin
                    if (cnt == START_PT) begin
                        if (bit_val) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            cnt     <= RELOAD;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_PT) begin
                        shift <= {bit_val, shift[7:1]};
                        cnt   <= RELOAD;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_PT) begin
                        cnt <= '0;
                        if (bit_val) begin
                            data  <= shift;
                            good  <= 1'b1;
                            state <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Robot-side command receiver: byte handshake register, command decode and
// link watchdog on top of the uart_rx_frame deserialiser.
module uart_cmd_rx
    import robot_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = BAUD_DIV_50M_9600,
    parameter int TIMEOUT_CLKS = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] data_received,
    output logic [1:0] cmd_mode,
    output logic [2:0] cmd_dir,
    output logic       cmd_active,
    output logic       frame_err,
    output logic       fmt_err,
    output logic       overrun,
    output logic       timeout
);

    localparam int WD_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    logic [7:0]      rx_byte;
    logic            rx_good;
    logic            rx_frame_err;
    logic            cmd_ok;
    mode_t           dec_mode;
    logic [2:0]      dec_dir;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_armed;

    uart_rx_frame #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_frame (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (rx_byte),
        .good     (rx_good),
        .frame_err(rx_frame_err)
    );

    assign cmd_ok   = rx_good && (rx_byte[2:0] == 3'b000);
    assign dec_mode = rx_byte[7:6];
    assign dec_dir  = rx_byte[5:3];

    // Handshake: a byte is transferred on every cycle where valid & ready are
    // both high; valid then drops unless a new byte lands in that same cycle.
    // A new byte arriving while the previous one is unaccepted replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid         <= 1'b0;
            data_received <= '0;
            cmd_mode      <= '0;
            cmd_dir       <= '0;
            cmd_active    <= 1'b0;
            frame_err     <= 1'b0;
            fmt_err       <= 1'b0;
            overrun       <= 1'b0;
            timeout       <= 1'b0;
            wd_cnt        <= '0;
            wd_armed      <= 1'b0;
        end else begin
            frame_err <= rx_frame_err;
            fmt_err   <= rx_good && (rx_byte[2:0] != 3'b000);
            overrun   <= rx_good && valid && !ready;
            timeout   <= 1'b0;

            if (rx_good) begin
                data_received <= rx_byte;
                valid         <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            // A fresh command outranks an expiry landing in the same cycle.
            if (cmd_ok) begin
                cmd_mode   <= dec_mode;
                cmd_dir    <= dec_dir;
                cmd_active <= 1'b1;
                wd_cnt     <= '0;
                wd_armed   <= 1'b1;
            end else if (wd_armed) begin
                if (wd_cnt == WD_W'(TIMEOUT_CLKS - 1)) begin
                    cmd_mode   <= '0;
                    cmd_dir    <= DIR_STOP;
                    cmd_active <= 1'b0;
                    timeout    <= 1'b1;
                    wd_armed   <= 1'b0;
                    wd_cnt     <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: table vectors, random frames against a
// byte-level reference model, and hand sequences for overrun, glitch, watchdog and reset.
module tb_uart_cmd_rx;
    import robot_cmd_pkg::*;

    localparam int CPB = 16;
    localparam int TMO = 2000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic       valid;
    logic [7:0] data_received;
    logic [1:0] cmd_mode;
    logic [2:0] cmd_dir;
    logic       cmd_active;
    logic       frame_err;
    logic       fmt_err;
    logic       overrun;
    logic       timeout;

    uart_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .valid        (valid),
        .ready        (ready),
        .data_received(data_received),
        .cmd_mode     (cmd_mode),
        .cmd_dir      (cmd_dir),
        .cmd_active   (cmd_active),
        .frame_err    (frame_err),
        .fmt_err      (fmt_err),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output monitor ----------------
    int         n_valid_cyc = 0;
    int         n_fmt = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         n_tmo = 0;
    int         valid_rise_cyc = 0;
    int         tmo_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) n_valid_cyc <= n_valid_cyc + 1;
            if (valid && !prev_valid) valid_rise_cyc <= cyc;
            if (valid && ready) got_q.push_back(data_received);
            if (fmt_err) n_fmt <= n_fmt + 1;
            if (frame_err) n_ferr <= n_ferr + 1;
            if (overrun) n_ovr <= n_ovr + 1;
            if (timeout) begin
                n_tmo   <= n_tmo + 1;
                tmo_cyc <= cyc;
            end
        end
        prev_valid <= valid;
    end

    // ---------------- scoreboard and reference model ----------------
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_err = 0;
    int m_mode = 0;
    int m_dir = 0;
    bit m_active = 1'b0;
    int t_fall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low);
        t_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (stop_ok) begin
            drive_bit(1'b1);
        end else begin
            drive_bit(1'b0);
            repeat (hold_low) @(posedge clk);
            rx = 1'b1;
        end
    endtask

    // Sends one frame and checks delivery, pulses and held command outputs.
    task automatic run_frame(input string name, input logic [7:0] b, input bit stop_ok,
                             input int hold_low, input int gap,
                             input int e_mode, input int e_dir, input bit e_active);
        int         got0, vc0, fmt0, ferr0, ovr0;
        bit         is_fmt;
        logic [7:0] e_byte;
        got0   = got_q.size();
        vc0    = n_valid_cyc;
        fmt0   = n_fmt;
        ferr0  = n_ferr;
        ovr0   = n_ovr;
        is_fmt = stop_ok && (b % 8 != 0);
        if (stop_ok) exp_q.push_back(b);
        send_frame(b, stop_ok, hold_low);
        tick(gap);
        check({name, "_valid_cycles"}, n_valid_cyc - vc0, stop_ok ? 1 : 0);
        check({name, "_accepted"}, got_q.size() - got0, stop_ok ? 1 : 0);
        if (stop_ok && exp_q.size() > 0) begin
            e_byte = exp_q.pop_front();
            if (got_q.size() > got0) check({name, "_data"}, got_q[got0], e_byte);
        end
        check({name, "_fmt_err"}, n_fmt - fmt0, is_fmt ? 1 : 0);
        check({name, "_frame_err"}, n_ferr - ferr0, stop_ok ? 0 : 1);
        check({name, "_overrun"}, n_ovr - ovr0, 0);
        check({name, "_mode"}, cmd_mode, e_mode);
        check({name, "_dir"}, cmd_dir, e_dir);
        check({name, "_active"}, cmd_active, e_active);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         mode;
        int         dir;
        bit         active;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int         lat, t0, v0, g0, o0, nocmd;
        logic [7:0] b;
        bit         stop_ok, is_cmd;

        // ---------------- reset ----------------
        tick(3);
        check("reset_outputs",
              {valid, data_received, cmd_mode, cmd_dir, cmd_active, frame_err, fmt_err, overrun, timeout}, 0);
        check("reset_state", dut.u_frame.state, RX_IDLE);
        rst_n = 1'b1;
        ready = 1'b1;
        tick(5);

        // ---------------- table-driven vectors ----------------
        vecs[0] = '{8'h48, 1'b1, 1, DIR_FWD,   1'b1};
        vecs[1] = '{8'h4B, 1'b1, 1, DIR_FWD,   1'b1};
        vecs[2] = '{8'h28, 1'b1, 0, DIR_RIGHT, 1'b1};
        vecs[3] = '{8'h48, 1'b0, 0, DIR_RIGHT, 1'b1};
        vecs[4] = '{8'h28, 1'b1, 0, DIR_RIGHT, 1'b1};
        vecs[5] = '{8'hC0, 1'b1, 3, DIR_STOP,  1'b1};
        vecs[6] = '{8'h97, 1'b1, 3, DIR_STOP,  1'b1};
        vecs[7] = '{8'h38, 1'b1, 0, DIR_BACK,  1'b1};
        vecs[8] = '{8'h20, 1'b1, 0, DIR_HALT,  1'b1};
        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop_ok, 40, 6,
                      vecs[i].mode, vecs[i].dir, vecs[i].active);
            if (i == 0) begin
                lat = valid_rise_cyc - t_fall;
                check("latency_window", (lat >= 154 && lat <= 158) ? 1 : 0, 1);
            end
        end
        m_mode = 0; m_dir = DIR_HALT; m_active = 1'b1;

        // ---------------- start-bit glitch ----------------
        v0 = n_valid_cyc; t0 = n_ferr + n_fmt;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        rx = 1'b1;
        tick(40);
        check("glitch_no_valid", n_valid_cyc - v0, 0);
        check("glitch_no_err", n_ferr + n_fmt - t0, 0);
        check("glitch_state", dut.u_frame.state, RX_IDLE);

        // ---------------- overrun ----------------
        ready = 1'b0;
        o0 = n_ovr; g0 = got_q.size();
        send_frame(8'h48, 1'b1, 0);
        tick(4);
        check("ovr_valid_held1", valid, 1);
        check("ovr_data1", data_received, 8'h48);
        send_frame(8'h68, 1'b1, 0);
        tick(4);
        check("ovr_pulse", n_ovr - o0, 1);
        check("ovr_valid_held2", valid, 1);
        check("ovr_data2", data_received, 8'h68);
        check("ovr_none_accepted", got_q.size() - g0, 0);
        check("ovr_dir", cmd_dir, DIR_RIGHT);
        ready = 1'b1;
        tick(1);
        check("ovr_valid_clear", valid, 0);
        m_mode = 1; m_dir = DIR_RIGHT; m_active = 1'b1;
        tick(4);

        // ---------------- random frames vs reference model ----------------
        nocmd = 0;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 || nocmd >= 2) b = b & 8'hF8;
            stop_ok = ($urandom_range(0, 7) != 0) || (nocmd >= 2);
            is_cmd = stop_ok && (b % 8 == 0);
            nocmd = is_cmd ? 0 : nocmd + 1;
            if (is_cmd) begin
                m_mode = b / 64;
                m_dir = (b / 8) % 8;
                m_active = 1'b1;
            end
            run_frame($sformatf("rand%0d", i), b, stop_ok, $urandom_range(20, 40),
                      $urandom_range(4, 30), m_mode, m_dir, m_active);
        end

        // ---------------- watchdog ----------------
        run_frame("tmo_cmd", 8'h28, 1'b1, 0, 4, 0, DIR_RIGHT, 1'b1);
        t0 = n_tmo;
        tick(1500);
        check("tmo_not_early", n_tmo - t0, 0);
        check("tmo_still_active", cmd_active, 1);
        for (int k = 0; k < 1000 && n_tmo == t0; k++) tick(1);
        tick(5);
        check("tmo_pulse_once", n_tmo - t0, 1);
        check("tmo_delay", tmo_cyc - valid_rise_cyc, TMO);
        check("tmo_mode", cmd_mode, 0);
        check("tmo_dir", cmd_dir, DIR_STOP);
        check("tmo_active", cmd_active, 0);

        // ---------------- reset mid-frame ----------------
        run_frame("pre_rst", 8'h68, 1'b1, 0, 4, 1, DIR_RIGHT, 1'b1);
        b = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rst_n = 1'b0;
        rx = 1'b1;
        tick(1);
        check("rst_mid_outputs",
              {valid, data_received, cmd_mode, cmd_dir, cmd_active, frame_err, fmt_err, overrun, timeout}, 0);
        check("rst_mid_state", dut.u_frame.state, RX_IDLE);
        tick(3);
        rst_n = 1'b1;
        v0 = n_valid_cyc;
        tick(300);
        check("rst_no_valid", n_valid_cyc - v0, 0);
        check("rst_after_outputs",
              {valid, data_received, cmd_mode, cmd_dir, cmd_active, frame_err, fmt_err, overrun, timeout}, 0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
